// File: rtl/touch_event_filter.sv
`default_nettype none
// ============================================================================
// Module   : touch_event_filter
// Purpose  : Debounces the pen-down level and converts raw 12-bit ADC samples
//            into 800x480 LCD pixel coordinates, with the axes inverted to
//            match the panel. Emits PRESS / MOVE / RELEASE events through a
//            small first-word-fall-through event FIFO with valid/ready.
// Macro    : TOUCH_FILTER_AVG_EN - when defined, four strobed samples are
//            summed and averaged per coordinate; when undefined every
//            accepted strobe is a complete sample on its own.
// Ports    : iCLK        - system clock
//            iRST_n      - asynchronous active-low reset
//            iTOUCH_IRQ  - one-cycle strobe qualifying iX_COORD / iY_COORD
//            iX_COORD    - raw 12-bit ADC X
//            iY_COORD    - raw 12-bit ADC Y
//            iTouch      - raw pen-down level
//            oEVT_VALID  - event FIFO non-empty
//            iEVT_READY  - consumer accepts the head entry
//            oEVT_TYPE   - 00 PRESS, 01 MOVE, 10 RELEASE
//            oEVT_X      - pixel X 0..799
//            oEVT_Y      - pixel Y 0..479
//            oDROP_CNT   - events lost to a full FIFO, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module touch_event_filter #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int RELEASE_CYCLES  = 2_500_000,
  parameter int MOVE_THRESH     = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iTOUCH_IRQ,
  input  logic [11:0] iX_COORD,
  input  logic [11:0] iY_COORD,
  input  logic        iTouch,
  output logic        oEVT_VALID,
  input  logic        iEVT_READY,
  output logic [1:0]  oEVT_TYPE,
  output logic [9:0]  oEVT_X,
  output logic [8:0]  oEVT_Y,
  output logic [7:0]  oDROP_CNT
);

  localparam int c_TMR_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam int c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [c_TMR_W-1:0] c_DEB_LAST = c_TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_REL_LAST = c_TMR_W'(RELEASE_CYCLES - 1);
  localparam logic [c_AW:0]      c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [9:0]         c_THR_X    = 10'(MOVE_THRESH);
  localparam logic [8:0]         c_THR_Y    = 9'(MOVE_THRESH);

  localparam logic [1:0] c_EVT_PRESS   = 2'b00;
  localparam logic [1:0] c_EVT_MOVE    = 2'b01;
  localparam logic [1:0] c_EVT_RELEASE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEB      = 3'd1,
    S_ARMED    = 3'd2,
    S_DOWN     = 3'd3,
    S_REL_PEND = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_TMR_W-1:0] r_tmr;

  // Averaged / raw sample, valid for one cycle after the completing strobe
  logic [11:0] r_avg_x;
  logic [11:0] r_avg_y;
  logic        r_avg_vld;

  // Strobes are only meaningful while the pen is established as down
  logic w_accept_state;
  assign w_accept_state = (r_state == S_ARMED) || (r_state == S_DOWN);

  // --------------------------------------------------------------------------
  // Sample stage
  // --------------------------------------------------------------------------
`ifdef TOUCH_FILTER_AVG_EN
  logic [13:0] r_acc_x;
  logic [13:0] r_acc_y;
  logic [1:0]  r_smp;
  logic [13:0] w_sum_x;
  logic [13:0] w_sum_y;

  assign w_sum_x = r_acc_x + {2'b00, iX_COORD};
  assign w_sum_y = r_acc_y + {2'b00, iY_COORD};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_smp     <= '0;
      r_avg_x   <= '0;
      r_avg_y   <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (!w_accept_state) begin
        // Outside ARMED/DOWN the accumulator is held clear, so arming and
        // returning from REL_PEND always start a fresh group of four.
        r_acc_x <= '0;
        r_acc_y <= '0;
        r_smp   <= '0;
      end else if (iTOUCH_IRQ) begin
        if (r_smp == 2'd3) begin
          r_avg_x   <= 12'(w_sum_x >> 2);
          r_avg_y   <= 12'(w_sum_y >> 2);
          r_avg_vld <= 1'b1;
          r_acc_x   <= '0;
          r_acc_y   <= '0;
          r_smp     <= '0;
        end else begin
          r_acc_x <= w_sum_x;
          r_acc_y <= w_sum_y;
          r_smp   <= r_smp + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_avg_x   <= '0;
      r_avg_y   <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= w_accept_state && iTOUCH_IRQ;
      if (w_accept_state && iTOUCH_IRQ) begin
        r_avg_x <= iX_COORD;
        r_avg_y <= iY_COORD;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Scale stage: invert axis and map 0..4095 onto the panel resolution
  // --------------------------------------------------------------------------
  logic [11:0] w_inv_x;
  logic [11:0] w_inv_y;
  logic [9:0]  w_px;
  logic [8:0]  w_py;

  assign w_inv_x = 12'd4095 - r_avg_x;
  assign w_inv_y = 12'd4095 - r_avg_y;
  assign w_px    = 10'((22'(w_inv_x) * 22'd800) >> 12);
  assign w_py    = 9'((21'(w_inv_y) * 21'd480) >> 12);

  logic [9:0] r_last_x;
  logic [8:0] r_last_y;
  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic       w_move;

  assign w_dx   = (w_px >= r_last_x) ? (w_px - r_last_x) : (r_last_x - w_px);
  assign w_dy   = (w_py >= r_last_y) ? (w_py - r_last_y) : (r_last_y - w_py);
  assign w_move = (w_dx >= c_THR_X) || (w_dy >= c_THR_Y);

  // --------------------------------------------------------------------------
  // Event FSM; produces a registered push request for the FIFO
  // --------------------------------------------------------------------------
  logic        r_push;
  logic [20:0] r_push_evt; // {type, x, y}

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_last_x   <= '0;
      r_last_y   <= '0;
      r_push     <= 1'b0;
      r_push_evt <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iTouch) begin
            r_state <= S_DEB;
            r_tmr   <= '0;
          end
        end
        S_DEB: begin
          if (!iTouch) begin
            r_state <= S_IDLE;
          end else if (r_tmr == c_DEB_LAST) begin
            r_state <= S_ARMED;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_ARMED: begin
          if (!iTouch) begin
            r_state <= S_IDLE;
          end else if (r_avg_vld) begin
            r_push     <= 1'b1;
            r_push_evt <= {c_EVT_PRESS, w_px, w_py};
            r_last_x   <= w_px;
            r_last_y   <= w_py;
            r_state    <= S_DOWN;
          end
        end
        S_DOWN: begin
          if (r_avg_vld && w_move) begin
            r_push     <= 1'b1;
            r_push_evt <= {c_EVT_MOVE, w_px, w_py};
            r_last_x   <= w_px;
            r_last_y   <= w_py;
          end
          if (!iTouch) begin
            r_state <= S_REL_PEND;
            r_tmr   <= '0;
          end
        end
        S_REL_PEND: begin
          if (iTouch) begin
            r_state <= S_DOWN;
          end else if (r_tmr == c_REL_LAST) begin
            r_push     <= 1'b1;
            r_push_evt <= {c_EVT_RELEASE, r_last_x, r_last_y};
            r_state    <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FWFT event FIFO
  // --------------------------------------------------------------------------
  logic [20:0]   r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr;
  logic [c_AW-1:0] r_rd;
  logic [c_AW:0]   r_count;
  logic [c_AW:0]   w_count_nxt;
  logic            r_valid;
  logic [7:0]      r_drop;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;

  assign w_pop  = r_valid && iEVT_READY;
  assign w_full = (r_count == c_DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr   = r_push && (!w_full || w_pop);
  assign w_drop = r_push && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_drop  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= r_push_evt;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign oEVT_VALID = r_valid;
  assign oEVT_TYPE  = r_mem[r_rd][20:19];
  assign oEVT_X     = r_mem[r_rd][18:9];
  assign oEVT_Y     = r_mem[r_rd][8:0];
  assign oDROP_CNT  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_touch_event_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_touch_event_filter
// Purpose  : Directed scoreboard bench for touch_event_filter. Stimulus pushes
//            hand-computed expected events; a negedge monitor pops and
//            compares each handshaken event. Works with or without
//            TOUCH_FILTER_AVG_EN (a sample is four equal strobes when on).
// Revision : 1.0 - initial release
// ============================================================================
module tb_touch_event_filter;

  localparam int DEB = 8;
  localparam int REL = 20;

  localparam logic [1:0] PRESS   = 2'b00;
  localparam logic [1:0] MOVE    = 2'b01;
  localparam logic [1:0] RELEASE = 2'b10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq   = 1'b0;
  logic        touch = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] xin   = '0;
  logic [11:0] yin   = '0;
  logic        evt_valid;
  logic [1:0]  evt_type;
  logic [9:0]  evt_x;
  logic [8:0]  evt_y;
  logic [7:0]  drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [20:0] exp_q [$];
  logic [20:0] mon_exp;
  logic [20:0] mon_got;

  touch_event_filter #(
    .DEBOUNCE_CYCLES(DEB),
    .RELEASE_CYCLES (REL),
    .MOVE_THRESH    (4),
    .FIFO_DEPTH     (4)
  ) u_dut (
    .iCLK      (clk),
    .iRST_n    (rst_n),
    .iTOUCH_IRQ(irq),
    .iX_COORD  (xin),
    .iY_COORD  (yin),
    .iTouch    (touch),
    .oEVT_VALID(evt_valid),
    .iEVT_READY(ready),
    .oEVT_TYPE (evt_type),
    .oEVT_X    (evt_x),
    .oEVT_Y    (evt_y),
    .oDROP_CNT (drop_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: a handshake seen at the negedge is consumed on the next posedge
  always @(negedge clk) begin
    if (rst_n && evt_valid && ready) begin
      mon_got = {evt_type, evt_x, evt_y};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got type=%0d x=%0d y=%0d, required no event",
                 evt_type, evt_x, evt_y);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got != mon_exp) begin
          miscompares++;
          $display("FAIL event: got type=%0d x=%0d y=%0d, required type=%0d x=%0d y=%0d",
                   evt_type, evt_x, evt_y, mon_exp[20:19], mon_exp[18:9], mon_exp[8:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] t, input int px, input int py);
    exp_q.push_back({t, 10'(px), 9'(py)});
  endtask

  // One complete sample; ends one cycle after the completing strobe
  task automatic sample(input logic [11:0] sx, input logic [11:0] sy);
`ifdef TOUCH_FILTER_AVG_EN
    for (int i = 0; i < 4; i++) begin
      irq = 1'b1; xin = sx; yin = sy;
      tick(1);
    end
`else
    irq = 1'b1; xin = sx; yin = sy;
    tick(1);
`endif
    irq = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(3);
    chk("reset_valid", evt_valid, 0);
    chk("reset_type",  evt_type,  0);
    chk("reset_x",     evt_x,     0);
    chk("reset_y",     evt_y,     0);
    chk("reset_drop",  drop_cnt,  0);
    rst_n = 1'b1;
    tick(2);

    // ---------------- glitch: DEB-2 high cycles, strobe in the last ----------------
    touch = 1'b1;
    tick(DEB - 3);
    irq = 1'b1; xin = 12'd100; yin = 12'd100;
    tick(1);
    irq = 1'b0;
    touch = 1'b0;
    tick(10);
    chk("glitch_no_event", evt_valid, 0);

    // ---------------- press with latency check ----------------
    touch = 1'b1;
    tick(DEB + 3);
    expect_evt(PRESS, 399, 239);
    sample(12'd2048, 12'd2048);
    @(negedge clk); chk("press_lat_n1", evt_valid, 0);
    @(negedge clk); chk("press_lat_n2", evt_valid, 0);
    @(negedge clk); chk("press_lat_n3", evt_valid, 1);
    chk("press_drop", drop_cnt, 0);
    @(posedge clk); #1;
    ready = 1'b1;
    tick(3);

    // ---------------- move threshold ----------------
    expect_evt(MOVE, 403, 239);
    sample(12'd2030, 12'd2048);
    tick(6);
    sample(12'd2021, 12'd2048);   // px 405, delta 2: no event
    tick(6);

    // ---------------- boundaries, back-to-back samples ----------------
    expect_evt(MOVE, 799, 479);
    expect_evt(MOVE, 0, 0);
    sample(12'd0, 12'd0);
    sample(12'd4095, 12'd4095);
    tick(6);
    expect_evt(MOVE, 399, 239);
    sample(12'd2048, 12'd2048);
    tick(6);

    // ---------------- release bounce, then real release ----------------
    touch = 1'b0;
    tick(REL - 10);
    touch = 1'b1;
    tick(10);
    expect_evt(RELEASE, 399, 239);
    touch = 1'b0;
    tick(REL + 6);
    chk("release_seen", exp_q.size(), 0);

    // ---------------- overflow ----------------
    ready = 1'b0;
    touch = 1'b1;
    tick(DEB + 3);
    expect_evt(PRESS, 799, 239);
    expect_evt(MOVE,  599, 239);
    expect_evt(MOVE,  399, 239);
    expect_evt(MOVE,  199, 239);
    sample(12'd0,    12'd2048); tick(5);
    sample(12'd1024, 12'd2048); tick(5);
    sample(12'd2048, 12'd2048); tick(5);
    sample(12'd3072, 12'd2048); tick(5);
    sample(12'd4095, 12'd2048); tick(5);  // dropped
    sample(12'd1000, 12'd2048); tick(5);  // dropped
    chk("ovf_valid",  evt_valid, 1);
    chk("ovf_drop",   drop_cnt,  2);
    chk("ovf_head_x", evt_x,     799);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ovf_drain_valid", evt_valid, 1);
    end
    @(negedge clk);
    chk("ovf_drain_empty", evt_valid, 0);
    chk("ovf_all_popped", exp_q.size(), 0);

    // ---------------- async reset mid-REL_PEND with 3 queued ----------------
    @(posedge clk); #1;
    ready = 1'b0;
    sample(12'd0,    12'd2048); tick(5);
    sample(12'd2048, 12'd2048); tick(5);
    sample(12'd4095, 12'd2048); tick(5);
    chk("rst_pre_valid", evt_valid, 1);
    touch = 1'b0;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", evt_valid, 0);
    chk("rst_async_type",  evt_type,  0);
    chk("rst_async_x",     evt_x,     0);
    chk("rst_async_y",     evt_y,     0);
    chk("rst_async_drop",  drop_cnt,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    tick(2);

    // ---------------- full debounce required after reset ----------------
    touch = 1'b1;
    tick(DEB - 4);
    sample(12'd100, 12'd100);       // still debouncing: ignored
    tick(6);
    expect_evt(PRESS, 399, 239);
    sample(12'd2048, 12'd2048);
    tick(6);
    chk("post_rst_drop", drop_cnt, 0);

    // ---------------- drain, bounded ----------------
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
